au_nibble_seq: RTL and testbench

//  Sequencer that runs a wide add/subtract on the shared 4-bit arithmetic unit, one nibble per cycle, LSB first.

---
 rtl/au_nibble_seq.sv | 140 ++++++++++++++
 tb/tb_au_nibble_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_nibble_seq.sv
// ============================================================================
// Module  : au_nibble_seq
// Brief   : Runs a wide add/subtract on an external 4-bit combinational AU,
//           one nibble per cycle, LSB first. Optional macro AU_SEQ_OVF_EN
//           adds a registered signed-overflow output o_ovf.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module au_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [1:0]             i_op,
  input  logic                   i_cin,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  output logic [3:0]             o_au_a,
  output logic [3:0]             o_au_b,
  output logic                   o_au_cin,
  output logic                   o_au_sel0,
  output logic                   o_au_sel1,
  input  logic [3:0]             i_au_out,
  input  logic                   i_au_cout,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_result,
  output logic                   o_cout
`ifdef AU_SEQ_OVF_EN
  ,output logic                  o_ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] c_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [1:0]    r_op;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          w_run;
  logic          w_accept;
  logic          w_last;
  logic [IW+1:0] w_bit;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_idx == c_LAST);
  assign w_bit    = {r_idx, 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_op    <= i_op;
      r_idx   <= '0;
      r_carry <= i_cin;
    end else if (w_run) begin
      r_result[w_bit +: 4] <= i_au_out;
      r_carry              <= i_au_cout;
      // idx parks on the last nibble; only a new start rewinds it
      if (w_last) r_cout <= i_au_cout;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

`ifdef AU_SEQ_OVF_EN
  logic w_beff;
  logic r_ovf;

  always_comb begin
    w_beff = 1'b0;
    case (r_op)
      2'b00:   w_beff = r_b[W-1];
      2'b01:   w_beff = ~r_b[W-1];
      2'b10:   w_beff = 1'b0;
      default: w_beff = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ovf <= 1'b0;
    else if (w_run && w_last)
      r_ovf <= (r_a[W-1] == w_beff) && (i_au_out[3] != r_a[W-1]);
  end

  assign o_ovf = r_ovf;
`endif

  assign o_au_a    = w_run ? r_a[w_bit +: 4] : 4'h0;
  assign o_au_b    = w_run ? r_b[w_bit +: 4] : 4'h0;
  assign o_au_cin  = w_run & r_carry;
  assign o_au_sel0 = w_run & r_op[0];
  assign o_au_sel1 = w_run & r_op[1];
  assign o_busy    = w_run;
  assign o_done    = (r_state == S_DONE);
  assign o_result  = r_result;
  assign o_cout    = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_au_nibble_seq.sv
// ============================================================================
// Module  : tb_au_nibble_seq
// Brief   : Self-checking bench for au_nibble_seq with a behavioural AU and a
//           whole-word arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_au_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int TMO     = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   au_a, au_b, au_out;
  logic         au_cin, au_sel0, au_sel1, au_cout;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef AU_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  au_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_cin(cin),
    .i_a(a), .i_b(b),
    .o_au_a(au_a), .o_au_b(au_b), .o_au_cin(au_cin),
    .o_au_sel0(au_sel0), .o_au_sel1(au_sel1),
    .i_au_out(au_out), .i_au_cout(au_cout),
    .o_busy(busy), .o_done(done), .o_result(result), .o_cout(cout)
`ifdef AU_SEQ_OVF_EN
    , .o_ovf(ovf)
`endif
  );

  // Combinational 4-bit AU: A + {B, ~B, 0, F} + cin
  always_comb begin
    logic [3:0] bsel;
    case ({au_sel1, au_sel0})
      2'b00:   bsel = au_b;
      2'b01:   bsel = ~au_b;
      2'b10:   bsel = 4'h0;
      default: bsel = 4'hF;
    endcase
    {au_cout, au_out} = {1'b0, au_a} + {1'b0, bsel} + {4'h0, au_cin};
  end

  function automatic logic [W-1:0] beff_of(input logic [1:0] f_op, input logic [W-1:0] f_b);
    case (f_op)
      2'b00:   return f_b;
      2'b01:   return ~f_b;
      2'b10:   return '0;
      default: return '1;
    endcase
  endfunction

  // Reference: {cout, result} of the whole-word operation
  function automatic logic [W:0] ref_sum(input logic [1:0] f_op, input logic f_cin,
                                         input logic [W-1:0] f_a, input logic [W-1:0] f_b);
    return {1'b0, f_a} + {1'b0, beff_of(f_op, f_b)} + {{W{1'b0}}, f_cin};
  endfunction

  function automatic logic ref_ovf(input logic [1:0] f_op, input logic f_cin,
                                   input logic [W-1:0] f_a, input logic [W-1:0] f_b);
    logic [W:0]   s;
    logic [W-1:0] be;
    s  = ref_sum(f_op, f_cin, f_a, f_b);
    be = beff_of(f_op, f_b);
    return (f_a[W-1] == be[W-1]) && (s[W-1] != f_a[W-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for one edge, then scrambles the operand inputs.
  task automatic start_op(input logic [1:0] t_op, input logic t_cin,
                          input logic [W-1:0] t_a, input logic [W-1:0] t_b);
    start = 1'b1; op = t_op; cin = t_cin; a = t_a; b = t_b;
    tick();
    start = 1'b0;
    op = 2'($urandom); cin = 1'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < TMO) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if ({busy, done, cout, result, au_a, au_b, au_cin, au_sel0, au_sel1} !== '0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b cout=%b result=%h au=%h/%h/%b/%b%b, required all 0",
               busy, done, cout, result, au_a, au_b, au_cin, au_sel1, au_sel0);
    end
`ifdef AU_SEQ_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]   t_op  [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
    logic         t_cin [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] t_a   [6] = '{16'h1234, 16'h0005, 16'h0007, 16'hFFFF, 16'h0000, 16'h00F0};
    logic [W-1:0] t_b   [6] = '{16'h0FFF, 16'h0007, 16'h0005, 16'h0001, 16'h1234, 16'hABCD};
    logic [W-1:0] t_res [6] = '{16'h2233, 16'hFFFE, 16'h0002, 16'h0000, 16'hFFFF, 16'h00F1};
    logic         t_co  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int k;
    for (int i = 0; i < 6; i++) begin
      start_op(t_op[i], t_cin[i], t_a[i], t_b[i]);
      wait_done(k);
      n_vec++;
      if (k != NIBBLES || result !== t_res[i] || cout !== t_co[i]) begin
        n_err++;
        $display("FAIL directed[%0d]: latency=%0d result=%h cout=%b, required latency=%0d result=%h cout=%b",
                 i, k, result, cout, NIBBLES, t_res[i], t_co[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [1:0]   r_op;
    logic         r_cin;
    logic [W-1:0] r_a, r_b;
    logic [W:0]   exp;
    int k;
    for (int i = 0; i < 30; i++) begin
      r_op = 2'($urandom); r_cin = 1'($urandom); r_a = W'($urandom); r_b = W'($urandom);
      exp = ref_sum(r_op, r_cin, r_a, r_b);
      start_op(r_op, r_cin, r_a, r_b);
      n_vec++;
      if ({busy, au_a, au_b, au_cin, au_sel1, au_sel0} !== {1'b1, r_a[3:0], r_b[3:0], r_cin, r_op}) begin
        n_err++;
        $display("FAIL first_nibble[%0d]: busy=%b au=%h/%h/%b/%b%b, required 1 %h/%h/%b/%b",
                 i, busy, au_a, au_b, au_cin, au_sel1, au_sel0, r_a[3:0], r_b[3:0], r_cin, r_op);
      end
      wait_done(k);
      n_vec++;
      if (k != NIBBLES || {cout, result} !== exp) begin
        n_err++;
        $display("FAIL random[%0d]: latency=%0d cout/result=%h, required latency=%0d %h",
                 i, k, {cout, result}, NIBBLES, exp);
      end
`ifdef AU_SEQ_OVF_EN
      n_vec++;
      if (ovf !== ref_ovf(r_op, r_cin, r_a, r_b)) begin
        n_err++;
        $display("FAIL random_ovf[%0d]: got %b required %b", i, ovf, ref_ovf(r_op, r_cin, r_a, r_b));
      end
`endif
      tick();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, result} !== exp || {au_a, au_b, au_cin, au_sel0, au_sel1} !== '0) begin
        n_err++;
        $display("FAIL hold[%0d]: done=%b busy=%b cout/result=%h au=%h%h, required 0 0 %h 0",
                 i, done, busy, {cout, result}, au_a, au_b, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] exp;
    int k;
    exp = ref_sum(2'd0, 1'b0, 16'h1111, 16'h2222);
    start_op(2'd0, 1'b0, 16'h1111, 16'h2222);
    tick();
    start = 1'b1; op = 2'd1; cin = 1'b1; a = 16'h9999; b = 16'h4444;
    tick();
    start = 1'b0;
    wait_done(k);
    n_vec++;
    if (k != NIBBLES - 2 || {cout, result} !== exp) begin
      n_err++;
      $display("FAIL ignore_start: remaining=%0d cout/result=%h, required %0d %h", k, {cout, result}, NIBBLES - 2, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W:0] e1, e2;
    int k;
    e1 = ref_sum(2'd1, 1'b1, 16'h8421, 16'h1248);
    e2 = ref_sum(2'd0, 1'b1, 16'h0F0F, 16'hF0F0);
    start_op(2'd1, 1'b1, 16'h8421, 16'h1248);
    wait_done(k);
    n_vec++;
    if ({cout, result} !== e1) begin
      n_err++;
      $display("FAIL b2b_first: cout/result=%h required %h", {cout, result}, e1);
    end
    start_op(2'd0, 1'b1, 16'h0F0F, 16'hF0F0);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(k);
    n_vec++;
    if (k != NIBBLES || {cout, result} !== e2) begin
      n_err++;
      $display("FAIL b2b_second: latency=%0d cout/result=%h, required %0d %h", k, {cout, result}, NIBBLES, e2);
    end
    tick();
  endtask

  task automatic test_midrun_reset();
    logic [W:0] exp;
    int seen;
    int k;
    start_op(2'd0, 1'b0, 16'h7777, 16'h5555);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, done, cout, result, au_a, au_b, au_cin, au_sel0, au_sel1} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: busy=%b done=%b result=%h au=%h/%h, required all 0",
               busy, done, result, au_a, au_b);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL aborted_done: got %0d done cycles, required 0", seen);
    end
    exp = ref_sum(2'd3, 1'b1, 16'h0102, 16'h0);
    start_op(2'd3, 1'b1, 16'h0102, 16'h0);
    wait_done(k);
    n_vec++;
    if (k != NIBBLES || {cout, result} !== exp) begin
      n_err++;
      $display("FAIL after_reset: latency=%0d cout/result=%h, required %0d %h", k, {cout, result}, NIBBLES, exp);
    end
    tick();
  endtask

`ifdef AU_SEQ_OVF_EN
  task automatic test_ovf();
    int k;
    start_op(2'd0, 1'b0, 16'h7FFF, 16'h0001);
    wait_done(k);
    n_vec++;
    if (result !== 16'h8000 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_add: result=%h ovf=%b required 8000 1", result, ovf);
    end
    tick();
    start_op(2'd1, 1'b1, 16'h8000, 16'h0001);
    wait_done(k);
    n_vec++;
    if (result !== 16'h7FFF || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sub: result=%h ovf=%b required 7FFF 1", result, ovf);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_midrun_reset();
`ifdef AU_SEQ_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
